// File: rtl/sha3_digest_streamer_if.sv
// sha3_digest_streamer_if
//   AXI4-Stream bus carrying the digest bytes out of sha3_digest_streamer.
//   Signals:
//     TDATA   DATA_WIDTH      beat data
//     TKEEP   DATA_WIDTH/8    byte enables
//     TVALID  1               beat valid
//     TREADY  1               downstream ready
//     TLAST   1               final beat of the digest
//   Modports: master (streamer side), slave (sink side).
interface sha3_digest_streamer_if #(
    parameter int unsigned DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   TDATA;
    logic [DATA_WIDTH/8-1:0] TKEEP;
    logic                    TVALID;
    logic                    TREADY;
    logic                    TLAST;

    modport master (
        output TDATA,
        output TKEEP,
        output TVALID,
        output TLAST,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TKEEP,
        input  TVALID,
        input  TLAST,
        output TREADY
    );
endinterface

// File: rtl/sha3_digest_streamer.sv
// sha3_digest_streamer
//   AXI4-Stream output stage for the SHA-3/SHAKE core. Captures a 1600-bit
//   Keccak state and serialises the digest in FIPS 202 byte order as
//   DATA_WIDTH-bit beats. SHAKE outputs longer than one rate block request
//   further squeeze permutations through squeeze_req.
//
//   Parameters:
//     DATA_WIDTH  beat width in bits (8, 16, 32, 64)
//     LEN_WIDTH   width of out_len and of the remaining-byte counter
//   Ports:
//     ACLK, ARESETN   clock, asynchronous active-low reset
//     state_in        Keccak state, state_in[x][y] = lane A[x,y]
//     state_valid     state_in valid
//     state_ready     block accepts state_in (IDLE and WAIT_SQZ)
//     TUSER           mode, sampled on accept from IDLE
//     out_len         SHAKE output length in bytes, sampled on accept from IDLE
//     squeeze_req     one-cycle request for the next permuted state
//     M_AXIS          AXI4-Stream master (TDATA/TKEEP/TVALID/TREADY/TLAST)
//
//   Build option: define SHA3_STREAM_BSWAP_EN to byte-reverse each beat
//   (first byte in the most-significant lane, TKEEP left-aligned).
module sha3_digest_streamer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [4:0][4:0][63:0]  state_in,
    input  logic                   state_valid,
    output logic                   state_ready,
    input  logic [2:0]             TUSER,
    input  logic [LEN_WIDTH-1:0]   out_len,
    output logic                   squeeze_req,
    sha3_digest_streamer_if.master M_AXIS
);

    localparam int unsigned          NB     = DATA_WIDTH / 8;
    localparam logic [LEN_WIDTH-1:0] NB_LEN = LEN_WIDTH'(NB);
    localparam logic [7:0]           NB_PTR = 8'(NB);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        WAIT_SQZ
    } state_t;

    state_t                 r_fsm;
    state_t                 w_fsm_next;

    logic [1599:0]          r_state;
    logic [2:0]             r_mode;
    logic [7:0]             r_byte_ptr;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic                   r_state_ready;
    logic                   r_sqz;

    logic [1599:0]          w_state_flat;
    logic [2:0]             w_mode_in;
    logic [LEN_WIDTH-1:0]   w_load_rem;
    logic                   w_load_empty;
    logic                   w_accept;
    logic                   w_streaming;
    logic                   w_hs;
    logic                   w_last;
    logic                   w_is_shake;
    logic [7:0]             w_rate;
    logic [7:0]             w_ptr_next;
    logic [LEN_WIDTH-1:0]   w_bytes_this;
    logic [DATA_WIDTH-1:0]  w_window;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [NB-1:0]          w_keep;

    // Lane k = x + 5y occupies bits [64k+63:64k], so byte n of the flat
    // vector is FIPS 202 state byte n.
    always_comb begin
        w_state_flat = '0;
        for (int unsigned y = 0; y < 5; y++) begin
            for (int unsigned x = 0; x < 5; x++) begin
                w_state_flat[64*(x+5*y) +: 64] = state_in[x][y];
            end
        end
    end

    // Mode 7 behaves as SHA3-256.
    assign w_mode_in = (TUSER == 3'd7) ? 3'd1 : TUSER;

    always_comb begin
        case (w_mode_in)
            3'd0:    w_load_rem = LEN_WIDTH'(28);
            3'd1:    w_load_rem = LEN_WIDTH'(32);
            3'd2:    w_load_rem = LEN_WIDTH'(48);
            3'd3:    w_load_rem = LEN_WIDTH'(64);
            3'd4,
            3'd5:    w_load_rem = out_len;
            default: w_load_rem = LEN_WIDTH'(200);
        endcase
    end

    assign w_load_empty = ((w_mode_in == 3'd4) || (w_mode_in == 3'd5)) && (out_len == '0);

    // state_ready is only ever high in IDLE or WAIT_SQZ.
    assign w_accept     = state_valid && r_state_ready;
    assign w_streaming  = (r_fsm == STREAM);
    assign w_hs         = w_streaming && M_AXIS.TREADY;
    assign w_last       = (r_remaining <= NB_LEN);
    assign w_bytes_this = (r_remaining < NB_LEN) ? r_remaining : NB_LEN;
    assign w_is_shake   = (r_mode == 3'd4) || (r_mode == 3'd5);
    assign w_rate       = (r_mode == 3'd4) ? 8'd168 : 8'd136;
    assign w_ptr_next   = r_byte_ptr + NB_PTR;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next    = r_fsm;
        M_AXIS.TVALID = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (w_accept && !w_load_empty) begin
                    w_fsm_next = STREAM;
                end
            end
            STREAM: begin
                M_AXIS.TVALID = 1'b1;
                if (w_hs) begin
                    if (w_last) begin
                        w_fsm_next = IDLE;
                    end else if (w_is_shake && (w_ptr_next == w_rate)) begin
                        w_fsm_next = WAIT_SQZ;
                    end
                end
            end
            WAIT_SQZ: begin
                if (w_accept) begin
                    w_fsm_next = STREAM;
                end
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    // state_ready and squeeze_req are registered so both read 0 in reset;
    // ready drops for the cycle after any accept, even one that stays in IDLE.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_ready <= 1'b0;
            r_sqz         <= 1'b0;
            r_mode        <= '0;
            r_byte_ptr    <= '0;
            r_remaining   <= '0;
        end else begin
            r_state_ready <= ((w_fsm_next == IDLE) || (w_fsm_next == WAIT_SQZ)) && !w_accept;
            r_sqz         <= (w_fsm_next == WAIT_SQZ) && (r_fsm != WAIT_SQZ);
            if ((r_fsm == IDLE) && w_accept) begin
                r_mode      <= w_mode_in;
                r_byte_ptr  <= '0;
                r_remaining <= w_load_rem;
            end else if ((r_fsm == WAIT_SQZ) && w_accept) begin
                r_byte_ptr  <= '0;
            end else if (w_hs) begin
                r_remaining <= r_remaining - w_bytes_this;
                r_byte_ptr  <= w_ptr_next;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_accept) begin
            r_state <= w_state_flat;
        end
    end

    assign w_window = DATA_WIDTH'(r_state >> {r_byte_ptr, 3'b000});

    always_comb begin
        w_data = '0;
        w_keep = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (LEN_WIDTH'(i) < w_bytes_this) begin
`ifdef SHA3_STREAM_BSWAP_EN
                w_data[8*(NB-1-i) +: 8] = w_window[8*i +: 8];
                w_keep[NB-1-i]          = 1'b1;
`else
                w_data[8*i +: 8]        = w_window[8*i +: 8];
                w_keep[i]               = 1'b1;
`endif
            end
        end
    end

    assign M_AXIS.TDATA = w_streaming ? w_data : '0;
    assign M_AXIS.TKEEP = w_streaming ? w_keep : '0;
    assign M_AXIS.TLAST = w_streaming && w_last;
    assign state_ready  = r_state_ready;
    assign squeeze_req  = r_sqz;

endmodule

// File: tb/tb_sha3_digest_streamer.sv
// tb_sha3_digest_streamer
//   Randomised scoreboard bench for sha3_digest_streamer (DATA_WIDTH = 64).
//   Expected beats come from a byte-level model of the output stream:
//   output byte j is byte (j mod rate) of squeeze block (j / rate).
`timescale 1ns/1ps
module tb_sha3_digest_streamer;

    localparam int unsigned DW = 64;
    localparam int unsigned NB = DW / 8;
    localparam int unsigned LW = 16;

    typedef logic [4:0][4:0][63:0] kstate_t;
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    kstate_t       state_in = '0;
    logic          state_valid = 1'b0;
    logic          state_ready;
    logic [2:0]    TUSER = '0;
    logic [LW-1:0] out_len = '0;
    logic          squeeze_req;

    sha3_digest_streamer_if #(.DATA_WIDTH(DW)) axis ();

    sha3_digest_streamer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .state_in    (state_in),
        .state_valid (state_valid),
        .state_ready (state_ready),
        .TUSER       (TUSER),
        .out_len     (out_len),
        .squeeze_req (squeeze_req),
        .M_AXIS      (axis)
    );

    always #5 ACLK = ~ACLK;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned sqz_count = 0;
    int unsigned beats_seen = 0;
    int          rdy_mode = 0;
    int          rdy_phase = 0;
    beat_t       exp_q[$];
    kstate_t     blk[8];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic kstate_t pattern_state();
        kstate_t s;
        for (int unsigned y = 0; y < 5; y++)
            for (int unsigned x = 0; x < 5; x++)
                s[x][y] = 64'h0706050403020100 + 64'(x + 5*y) * 64'h0808080808080808;
        return s;
    endfunction

    function automatic kstate_t random_state();
        kstate_t s;
        for (int unsigned y = 0; y < 5; y++)
            for (int unsigned x = 0; x < 5; x++)
                s[x][y] = {$urandom, $urandom};
        return s;
    endfunction

    function automatic logic [7:0] sbyte(input kstate_t st, input int unsigned n);
        logic [63:0] lane;
        int unsigned k;
        k = n / 8;
        lane = st[k % 5][k / 5];
        return lane[8*(n % 8) +: 8];
    endfunction

    function automatic int unsigned digest_len(input logic [2:0] mode, input int unsigned slen);
        case (mode)
            3'd0:       return 28;
            3'd1, 3'd7: return 32;
            3'd2:       return 48;
            3'd3:       return 64;
            3'd4, 3'd5: return slen;
            default:    return 200;
        endcase
    endfunction

    function automatic int unsigned rate_of(input logic [2:0] mode);
        case (mode)
            3'd4:    return 168;
            3'd5:    return 136;
            default: return 200;
        endcase
    endfunction

    task automatic push_expected(input int unsigned len, input int unsigned rate);
        int unsigned nbeats;
        int unsigned j;
        beat_t b;
        nbeats = (len + NB - 1) / NB;
        for (int unsigned m = 0; m < nbeats; m++) begin
            b = '0;
            for (int unsigned i = 0; i < NB; i++) begin
                j = m * NB + i;
                if (j < len) begin
`ifdef SHA3_STREAM_BSWAP_EN
                    b.data[8*(NB-1-i) +: 8] = sbyte(blk[j / rate], j % rate);
                    b.keep[NB-1-i] = 1'b1;
`else
                    b.data[8*i +: 8] = sbyte(blk[j / rate], j % rate);
                    b.keep[i] = 1'b1;
`endif
                end
            end
            b.last = (m == nbeats - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic send_state(input kstate_t st, input logic [2:0] mode, input logic [LW-1:0] len);
        bit done;
        @(negedge ACLK);
        state_in = st;
        TUSER = mode;
        out_len = len;
        state_valid = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 500 && !done; t++) begin
            if (state_ready) begin
                @(posedge ACLK);
                done = 1'b1;
            end else begin
                @(negedge ACLK);
            end
        end
        chk("accept", done, 1);
        @(negedge ACLK);
        state_valid = 1'b0;
        TUSER = 3'($urandom);
        out_len = LW'($urandom);
    endtask

    task automatic wait_sqz(input int unsigned target);
        int t;
        t = 0;
        while (sqz_count < target && t < 2000) begin
            @(negedge ACLK);
            t++;
        end
        chk("squeeze_wait", sqz_count >= target, 1);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || axis.TVALID) && t < 3000) begin
            @(negedge ACLK);
            t++;
        end
        chk("stream_done", (exp_q.size() == 0) && !axis.TVALID, 1);
    endtask

    task automatic run_txn(input logic [2:0] mode, input int unsigned slen, input string tag);
        int unsigned dlen, rate, nblk, base;
        dlen = digest_len(mode, slen);
        rate = rate_of(mode);
        nblk = (dlen == 0) ? 0 : (dlen + rate - 1) / rate;
        base = sqz_count;
        push_expected(dlen, rate);
        send_state(blk[0], mode, LW'(slen));
        for (int unsigned b = 1; b < nblk; b++) begin
            wait_sqz(base + b);
            repeat ($urandom_range(0, 3)) @(negedge ACLK);
            send_state(blk[b], 3'($urandom), LW'($urandom));
        end
        wait_done();
        chk({tag, "_squeezes"}, sqz_count - base, (nblk > 1) ? nblk - 1 : 0);
    endtask

    // Downstream ready generator: 0 always ready, 1 pattern 1,0,0, 2 random.
    initial begin
        axis.TREADY = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            case (rdy_mode)
                0:       axis.TREADY = 1'b1;
                1:       axis.TREADY = (rdy_phase % 3 == 0);
                default: axis.TREADY = 1'($urandom_range(0, 1));
            endcase
            rdy_phase++;
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks protocol rules.
    initial begin
        beat_t got, expb, prev_beat;
        bit prev_stall, exp_ready_next;
        prev_stall = 1'b0;
        exp_ready_next = 1'b0;
        prev_beat = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                prev_stall = 1'b0;
                exp_ready_next = 1'b0;
                continue;
            end
            got.data = axis.TDATA;
            got.keep = axis.TKEEP;
            got.last = axis.TLAST;
            if (exp_ready_next) chk("ready_after_last", state_ready, 1);
            exp_ready_next = 1'b0;
            if (prev_stall) begin
                chk("stall_valid_held", axis.TVALID, 1);
                chk("stall_beat_held", got, prev_beat);
            end
            if (axis.TVALID) chk("ready_low_while_streaming", state_ready, 0);
            if (squeeze_req) sqz_count++;
            if (axis.TVALID && axis.TREADY) begin
                beats_seen++;
                chk("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    expb = exp_q.pop_front();
                    chk("beat_data", got.data, expb.data);
                    chk("beat_keep", got.keep, expb.keep);
                    chk("beat_last", got.last, expb.last);
                end
                if (got.last) exp_ready_next = 1'b1;
            end
            prev_stall = axis.TVALID && !axis.TREADY;
            prev_beat = got;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base, lidx, slen;
        int unsigned lens[6] = '{1, 7, 8, 136, 168, 169};
        bit saw_valid;

        // Reset state
        #1;
        chk("reset_outputs", {axis.TVALID, axis.TLAST, axis.TKEEP, axis.TDATA, state_ready, squeeze_req}, '0);
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        chk("ready_before_first_clock", state_ready, 0);
        @(negedge ACLK);
        chk("ready_after_first_clock", state_ready, 1);

        // SHA3-224 on the byte-index pattern, always ready
        rdy_mode = 0;
        blk[0] = pattern_state();
`ifdef SHA3_STREAM_BSWAP_EN
        push_expected(28, 200);
`else
        exp_q.push_back('{data: 64'h0706050403020100, keep: 8'hFF, last: 1'b0});
        exp_q.push_back('{data: 64'h0F0E0D0C0B0A0908, keep: 8'hFF, last: 1'b0});
        exp_q.push_back('{data: 64'h1716151413121110, keep: 8'hFF, last: 1'b0});
        exp_q.push_back('{data: 64'h000000001B1A1918, keep: 8'h0F, last: 1'b1});
`endif
        send_state(blk[0], 3'd0, '0);
        chk("first_beat_latency", axis.TVALID, 1);
        wait_done();

        // SHA3-512 with 1,0,0 ready pattern
        rdy_mode = 1;
        rdy_phase = 0;
        blk[0] = random_state();
        run_txn(3'd3, 0, "sha512");

        // SHAKE128 200 bytes: one squeeze
        rdy_mode = 0;
        blk[0] = pattern_state();
        blk[1] = random_state();
        run_txn(3'd4, 200, "shake128_200");

        // Raw state, random backpressure
        rdy_mode = 2;
        blk[0] = pattern_state();
        run_txn(3'd6, 0, "raw");

        // Reset during beat 2 of SHA3-256
        rdy_mode = 0;
        blk[0] = pattern_state();
        base = beats_seen;
        push_expected(32, 200);
        send_state(blk[0], 3'd1, '0);
        for (int t = 0; t < 100 && beats_seen < base + 1; t++) @(negedge ACLK);
        chk("reset_scenario_beat1", beats_seen >= base + 1, 1);
        @(posedge ACLK);
        #2;
        chk("beat2_presented", axis.TVALID, 1);
        ARESETN = 1'b0;
        #1;
        chk("midstream_reset_outputs", {axis.TVALID, axis.TLAST, axis.TKEEP, axis.TDATA, state_ready, squeeze_req}, '0);
        exp_q.delete();
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("ready_after_reset_release", state_ready, 1);
        run_txn(3'd1, 0, "sha256_after_reset");

        // SHAKE256 with zero length
        base = beats_seen;
        send_state(blk[0], 3'd5, '0);
        chk("len0_ready_low", state_ready, 0);
        saw_valid = axis.TVALID;
        @(negedge ACLK);
        chk("len0_ready_back", state_ready, 1);
        repeat (5) begin
            saw_valid = saw_valid | axis.TVALID;
            @(negedge ACLK);
        end
        chk("len0_no_valid", saw_valid, 0);
        chk("len0_no_beats", beats_seen - base, 0);

        // Randomised transactions
        for (int n = 0; n < 14; n++) begin
            logic [2:0] mode;
            rdy_mode = $urandom_range(0, 2);
            mode = 3'($urandom_range(0, 7));
            lidx = $urandom_range(0, 6);
            slen = (lidx == 6) ? $urandom_range(1, 500) : lens[lidx];
            for (int b = 0; b < 8; b++) blk[b] = random_state();
            run_txn(mode, slen, "random");
        end

        repeat (3) @(negedge ACLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sha3_digest_streamer.md
Name: sha3_digest_streamer

Overview:
Parametrised AXI4-Stream output stage for the SHA-3/SHAKE core. It captures a 1600-bit Keccak state and emits the digest as DATA_WIDTH-bit beats with full TVALID/TREADY backpressure, and TKEEP/TLAST on a partial final beat. For SHAKE modes it generates outputs of arbitrary byte length. When the output needs more than one rate block, it requests further squeeze permutations from the Keccak round engine.

Parameters:
DATA_WIDTH, 64, output beat width in bits; legal values 8, 16, 32, 64.
LEN_WIDTH, 16, width of out_len and of the internal remaining-byte counter.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
state_in  in  [4:0][4:0][63:0]  Keccak state; state_in[x][y] = lane A[x,y]
state_valid  in  1  state_in valid
state_ready  out  1  block accepts state_in
TUSER  in  3  mode, sampled at accept: 0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256, 6 raw 1600-bit state, 7 treated as 1
out_len  in  LEN_WIDTH  SHAKE output length in bytes, sampled at accept
squeeze_req  out  1  one-cycle pulse requesting the next permuted state
M_AXIS_TDATA  out  DATA_WIDTH  output data
M_AXIS_TKEEP  out  DATA_WIDTH/8  byte enables
M_AXIS_TVALID  out  1  beat valid
M_AXIS_TREADY  in  1  downstream ready
M_AXIS_TLAST  out  1  final beat of digest

Behaviour:
- Reset value of every output is 0, including state_ready. After reset release, state_ready goes to 1 on the first clock. The FSM resets to IDLE. Reset asserted mid-stream aborts the transfer, and no TLAST is issued.
- FSM states are IDLE, STREAM and WAIT_SQZ.
- IDLE:
  - state_ready = 1.
  - On state_valid && state_ready: register all 1600 bits, latch the mode, set byte_ptr = 0, and load remaining.
  - remaining is 28/32/48/64 for modes 0-3, out_len for modes 4-5, and 200 for mode 6.
  - Next state is STREAM.
  - Exception: SHAKE with out_len = 0 consumes the state, emits nothing and stays in IDLE.
- Serialisation order follows FIPS 202 byte order:
  - Lane index k = x + 5y; byte b of lane k is bits [8b+7:8b].
  - Global byte index is 8k + b.
  - TDATA byte i (bits [8i+7:8i]) = state byte byte_ptr + i.
- STREAM:
  - state_ready = 0. TVALID is asserted from the cycle after accept, so first-beat latency is 1 clock.
  - TDATA, TKEEP and TLAST must be held stable while TVALID && !TREADY.
  - bytes_this = min(remaining, DATA_WIDTH/8).
  - TKEEP has its low bytes_this bits set. Unused TDATA bytes are 0.
  - TLAST = (remaining <= DATA_WIDTH/8).
  - On handshake: remaining -= bytes_this and byte_ptr += DATA_WIDTH/8.
  - If this was the TLAST beat, go to IDLE; state_ready is 1 in the following cycle.
  - SHAKE only: if byte_ptr reaches the rate (168 bytes for SHAKE128, 136 for SHAKE256) and remaining > 0, go to WAIT_SQZ with TVALID = 0. All legal DATA_WIDTH values divide both rates.
- WAIT_SQZ:
  - squeeze_req pulses high for exactly the first cycle in the state.
  - state_ready = 1.
  - On state_valid: capture the new state, set byte_ptr = 0 and return to STREAM. remaining and the mode are retained.
- TUSER and out_len are ignored outside the accept cycle.
- state_valid in STREAM is not consumed.

Optional Feature:
SHA3_STREAM_BSWAP_EN:
- Defined: each beat is byte-reversed. The first serialized byte appears in the most-significant TDATA byte, which suits big-endian host buses. TKEEP is left-aligned: its high bytes_this bits are set.
- Undefined: little-endian packing as in Behaviour.

Test Plan:
- Setup for all scenarios: DATA_WIDTH = 64; lane k = 0x0706050403020100 + k * 0x0808080808080808, so state byte n = n mod 256.
- SHA3-224 (TUSER = 0), TREADY = 1 -> 4 beats, on consecutive cycles:
  - 0x0706050403020100, TKEEP 0xFF
  - 0x0F0E0D0C0B0A0908, TKEEP 0xFF
  - 0x1716151413121110, TKEEP 0xFF
  - 0x000000001B1A1918, TKEEP 0x0F, TLAST = 1
- SHA3-512, TREADY toggling 1,0,0,1,... -> 8 beats, data stable across stalls, TLAST only on beat 8. state_ready returns 1 one cycle after the last handshake.
- SHAKE128, out_len = 200 -> 21 beats, then squeeze_req pulses once. After a second state is supplied: 4 more beats, beat 25 with TKEEP 0xFF and TLAST = 1; data restarts at byte 0 of the new state.
- Raw mode (TUSER = 6) -> 25 beats, last = 0xC7C6C5C4C3C2C1C0 with TLAST = 1. With SHA3_STREAM_BSWAP_EN, first beat = 0x0001020304050607.
- ARESETN low at beat 2 of SHA3-256 -> all outputs 0 immediately. After release, a new SHA3-256 request streams 4 beats correctly from byte 0.
- SHAKE256, out_len = 0 -> no TVALID. state_ready is 0 for exactly one cycle after accept.
